// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial wide adder: feeds one 4-bit slice per cycle through a single CLA, LSB slice first.
// Optional signed-overflow output enabled by defining CLA_SERIAL_OVF_EN.

module carry_look_ahead_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum_c,
    output logic       o_cout_c
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Flat two-level carry equations; no ripple between bit positions.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign o_sum_c  = w_p ^ w_c[3:0];
    assign o_cout_c = w_c[4];
endmodule

module cla_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int unsigned N     = WIDTH / 4;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [WIDTH-1:0]   r_out_sum;
    logic               r_out_cout;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;

    logic [3:0]         w_cla_sum;
    logic               w_cla_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_shift;

    carry_look_ahead_adder u_cla (
        .i_a      (r_a[3:0]),
        .i_b      (r_b[3:0]),
        .i_cin    (r_carry),
        .o_sum_c  (w_cla_sum),
        .o_cout_c (w_cla_cout)
    );

    assign w_last      = (r_cnt == CNT_W'(N - 1));
    // New nibble enters at the top; after N shifts the full sum is aligned.
    assign w_sum_shift = (r_sum >> 4) | (WIDTH'(w_cla_sum) << (WIDTH - 4));

    // State and handshake flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-flag decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // Operand shifters, carry chain register and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_sum   <= w_sum_shift;
                    r_carry <= w_cla_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out_sum  <= w_sum_shift;
                        r_out_cout <= w_cla_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CLA_SERIAL_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_out_ovf;

    // Operand MSBs are shifted away during RUN, so keep copies for the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            r_out_ovf <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_a_msb <= in_a[WIDTH-1];
                r_b_msb <= in_b[WIDTH-1];
            end
            if (r_state == S_RUN && w_last) begin
                r_out_ovf <= (r_a_msb == r_b_msb) && (w_sum_shift[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign out_ovf = r_out_ovf;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder (WIDTH=16): vector table, random ops vs arithmetic model, corner sequences.

module tb_cla_nibble_serial_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
`ifdef CLA_SERIAL_OVF_EN
    logic             out_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef CLA_SERIAL_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full transaction from IDLE; returns the result and cycles from accept to out_valid.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                          output logic [WIDTH-1:0] sum, output logic cout, output logic ovf,
                          output int lat);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_cin   = ~cin;
        check("busy_run", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        sum  = out_sum;
        cout = out_cout;
`ifdef CLA_SERIAL_OVF_EN
        ovf = out_ovf;
`else
        ovf = 1'b0;
`endif
        check("in_ready_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_clear", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t             vecs[5];
        logic [WIDTH-1:0] r_sum_got;
        logic             r_cout_got;
        logic             r_ovf_got;
        int               lat;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   model;
        int               acc_cyc[$];
        logic [WIDTH-1:0] res_sum[$];
        logic             res_cout[$];
        int               cyc;
        logic             acc_now;

        vecs[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
        vecs[1] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, cout: 1'b0};
        vecs[2] = '{a: 16'hAAAA, b: 16'h5555, cin: 1'b0, sum: 16'hFFFF, cout: 1'b0};
        vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
        vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_cout",  32'(out_cout),  32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, r_sum_got, r_cout_got, r_ovf_got, lat);
            check($sformatf("vec%0d_sum", i),  32'(r_sum_got),  32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(r_cout_got), 32'(vecs[i].cout));
            check($sformatf("vec%0d_lat", i),  32'(lat),        32'(N));
        end

        for (int i = 0; i < 30; i++) begin
            ra    = WIDTH'($urandom);
            rb    = WIDTH'($urandom);
            rc    = 1'($urandom_range(0, 1));
            model = (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc);
            run_op(ra, rb, rc, r_sum_got, r_cout_got, r_ovf_got, lat);
            check($sformatf("rnd%0d_sum", i),  32'(r_sum_got),  32'(model[WIDTH-1:0]));
            check($sformatf("rnd%0d_cout", i), 32'(r_cout_got), 32'(model[WIDTH]));
`ifdef CLA_SERIAL_OVF_EN
            begin
                int sv;
                sv = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
                check($sformatf("rnd%0d_ovf", i), 32'(r_ovf_got),
                      32'((sv > 32767 || sv < -32768) ? 1 : 0));
            end
`endif
        end

        // Backpressure: result must hold while out_ready is low; new in_valid ignored.
        in_a     = 16'h00FF;
        in_b     = 16'h0F01;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("bp_lat", 32'(lat), 32'(N));
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a     = 16'h0001;
            in_b     = 16'h0001;
            step();
            check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_sum", k),   32'(out_sum),   32'h1000);
            check($sformatf("bp%0d_ready", k), 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_release_sum",   32'(out_sum),   32'h1000);
        step();
        check("bp_no_accept", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of RUN.
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_sum",   32'(out_sum),   32'd0);
        check("mid_rst_cout",  32'(out_cout),  32'd0);
        step();
        rst = 1'b0;
        step();
        run_op(16'h0003, 16'h0004, 1'b0, r_sum_got, r_cout_got, r_ovf_got, lat);
        check("post_rst_sum", 32'(r_sum_got), 32'h0007);

        // Back-to-back with in_valid and out_ready both held high.
        in_a      = 16'hAAAA;
        in_b      = 16'h5555;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (res_sum.size() < 2 && cyc < 40) begin
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) begin
                res_sum.push_back(out_sum);
                res_cout.push_back(out_cout);
            end
            step();
            if (acc_now) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() == 1) begin
                    in_a = 16'h8000;
                    in_b = 16'h8000;
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        out_ready = 1'b0;
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
        check("b2b_results", 32'(res_sum.size()), 32'd2);
        if (acc_cyc.size() == 2)
            check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(N + 2));
        if (res_sum.size() == 2) begin
            check("b2b0_sum",  32'(res_sum[0]),  32'hFFFF);
            check("b2b0_cout", 32'(res_cout[0]), 32'd0);
            check("b2b1_sum",  32'(res_sum[1]),  32'h0000);
            check("b2b1_cout", 32'(res_cout[1]), 32'd1);
        end
        step();

`ifdef CLA_SERIAL_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, r_sum_got, r_cout_got, r_ovf_got, lat);
        check("ovf_pos_sum", 32'(r_sum_got), 32'h8000);
        check("ovf_pos_flag", 32'(r_ovf_got), 32'd1);
        run_op(16'hFFFF, 16'h0001, 1'b0, r_sum_got, r_cout_got, r_ovf_got, lat);
        check("ovf_neg_flag", 32'(r_ovf_got), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
